// File: rtl/seg_scan_driver.sv
// Four-digit common-anode 7-segment scan driver: per-frame snapshot, per-slot blanking.
// Optional SEG_SCAN_DIM_EN adds a dimLevel input that shortens the lit window.
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 5000
) (
  input  logic       Clk100M,
  input  logic       reset,
  input  logic [7:0] seg0,
  input  logic [7:0] seg1,
  input  logic [7:0] seg2,
  input  logic [7:0] seg3,
`ifdef SEG_SCAN_DIM_EN
  input  logic [1:0] dimLevel,
`endif
  output logic [7:0] cathode,
  output logic [3:0] anode,
  output logic       frameStart
);

  localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned VIS_W = SCAN_DIV - BLANK_CYC;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       dig;
  logic [7:0]       shadow [4];
  logic             isFrameStart_c;
  logic             litNow_c;
`ifdef SEG_SCAN_DIM_EN
  logic [1:0]       dimSh;
`endif

  // Frame-start detect and lit-window decode from the current scan position.
  always_comb begin
    isFrameStart_c = (cnt == '0) && (dig == 2'd0);
    litNow_c       = (32'(cnt) >= BLANK_CYC);
`ifdef SEG_SCAN_DIM_EN
    if (32'(cnt) >= BLANK_CYC + ((VIS_W * (32'(dimSh) + 32'd1)) >> 2))
      litNow_c = 1'b0;
`endif
  end

  always_ff @(posedge Clk100M) begin
    if (reset) begin
      cnt        <= '0;
      dig        <= 2'd0;
      for (int i = 0; i < 4; i++) shadow[i] <= 8'hFF;
      anode      <= 4'b1111;
      cathode    <= 8'hFF;
      frameStart <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
      dimSh      <= 2'd3;
`endif
    end else begin
      if (cnt == CNT_W'(SCAN_DIV - 1)) begin
        cnt <= '0;
        dig <= dig + 2'd1;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      frameStart <= isFrameStart_c;

      // Inputs are only captured here so a digit never changes mid-frame.
      if (isFrameStart_c) begin
        shadow[0] <= seg0;
        shadow[1] <= seg1;
        shadow[2] <= seg2;
        shadow[3] <= seg3;
`ifdef SEG_SCAN_DIM_EN
        dimSh     <= dimLevel;
`endif
      end

      // Blank slot head separates consecutive anodes, preventing ghosting.
      if (litNow_c) begin
        anode   <= ~(4'b0001 << dig);
        cathode <= shadow[dig];
      end else begin
        anode   <= 4'b1111;
        cathode <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed test-plan steps plus random stimulus,
// each cycle checked against a slot/phase reference model.
module tb_seg_scan_driver;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FL = 4 * SD;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] segIn [4];
  logic [1:0] dimIn;
  logic [7:0] cathode;
  logic [3:0] anode;
  logic       frameStart;

  always #5 clk = ~clk;

  seg_scan_driver #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .Clk100M(clk),
    .reset(reset),
    .seg0(segIn[0]),
    .seg1(segIn[1]),
    .seg2(segIn[2]),
    .seg3(segIn[3]),
`ifdef SEG_SCAN_DIM_EN
    .dimLevel(dimIn),
`endif
    .cathode(cathode),
    .anode(anode),
    .frameStart(frameStart)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: phase within the frame, snapshot and level, expected outputs.
  int         phase;
  int         lvl;
  int         cyc;
  int         fsCount;
  logic [7:0] snap [4];
  logic [3:0] eA;
  logic [7:0] eC;
  logic       eF;
  logic [3:0] prevA;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic tick(input logic rst);
    int  slot;
    int  c;
    int  litLen;
    logic lit;
    logic ovl;
    reset = rst;
    @(posedge clk);
    if (rst) begin
      eA = 4'hF; eC = 8'hFF; eF = 1'b0;
      phase = 0; lvl = 3; cyc = 0;
      for (int i = 0; i < 4; i++) snap[i] = 8'hFF;
    end else begin
      if (phase == 0) begin
        for (int i = 0; i < 4; i++) snap[i] = segIn[i];
`ifdef SEG_SCAN_DIM_EN
        lvl = int'(dimIn);
`else
        lvl = 3;
`endif
      end
      slot   = phase / SD;
      c      = phase % SD;
      litLen = ((SD - BC) * (lvl + 1)) / 4;
      lit    = (c >= BC) && (c < BC + litLen);
      eF     = (phase == 0);
      if (lit) begin
        eA = ~(4'(1) << slot);
        eC = snap[slot];
      end else begin
        eA = 4'hF;
        eC = 8'hFF;
      end
      phase = (phase + 1) % FL;
      cyc++;
    end
    #1;
    chk("anode", 8'(anode), 8'(eA));
    chk("cathode", cathode, eC);
    chk("frameStart", 8'(frameStart), 8'(eF));
    chk("oneLow", 8'($countones(~anode) <= 1), 8'd1);
    chk("blankCathode", (anode == 4'hF) ? cathode : 8'hFF, 8'hFF);
    ovl = ((~prevA) != 4'h0) && ((~anode) != 4'h0) && (prevA != anode);
    chk("overlap", 8'(ovl), 8'd0);
    if (frameStart) fsCount++;
    prevA = anode;
  endtask

  task automatic runTo(input int target);
    while (cyc < target) tick(1'b0);
  endtask

  initial begin
    prevA   = 4'hF;
    fsCount = 0;
    cyc     = 0;
    dimIn   = 2'd3;
    segIn[0] = 8'hC0; segIn[1] = 8'hF9; segIn[2] = 8'hA4; segIn[3] = 8'hB0;

    // Scenario 1: reset held 3 cycles, then the first frame.
    tick(1'b1); tick(1'b1); tick(1'b1);
    chk("rst_anode", 8'(anode), 8'h0F);
    chk("rst_cathode", cathode, 8'hFF);
    runTo(1);  chk("c1_fs", 8'(frameStart), 8'd1);
    runTo(2);  chk("c2_fs", 8'(frameStart), 8'd0);
    runTo(3);  chk("c3_anode", 8'(anode), 8'h0E); chk("c3_cat", cathode, 8'hC0);
    runTo(8);  chk("c8_cat", cathode, 8'hC0);
    runTo(9);  chk("c9_blank", 8'(anode), 8'h0F);
    runTo(11); chk("c11_anode", 8'(anode), 8'h0D); chk("c11_cat", cathode, 8'hF9);

    // Scenario 3: mid-slot change of seg1 is deferred to the next frame.
    runTo(12); segIn[1] = 8'h82;
    runTo(16); chk("c16_cat", cathode, 8'hF9);
    runTo(19); chk("c19_anode", 8'(anode), 8'h0B); chk("c19_cat", cathode, 8'hA4);
    runTo(27); chk("c27_anode", 8'(anode), 8'h07); chk("c27_cat", cathode, 8'hB0);
    runTo(33); chk("c33_fs", 8'(frameStart), 8'd1);
    runTo(43); chk("c43_anode", 8'(anode), 8'h0D); chk("c43_cat", cathode, 8'h82);

    // Scenario 4: one-cycle reset mid digit-1 slot, restart with a fresh snapshot.
    segIn[1] = 8'hF9;
    runTo(44);
    tick(1'b1);
    chk("mrst_anode", 8'(anode), 8'h0F);
    chk("mrst_fs", 8'(frameStart), 8'd0);
    runTo(1);  chk("mrst_c1_fs", 8'(frameStart), 8'd1);
    runTo(3);  chk("mrst_c3_cat", cathode, 8'hC0);

    // Scenarios 2 and 5: all-zero segments, free-run 10 frames.
    for (int i = 0; i < 4; i++) segIn[i] = 8'h00;
    tick(1'b1);
    fsCount = 0;
    runTo(10 * FL);
    chk("frameCount", 8'(fsCount), 8'd10);

`ifdef SEG_SCAN_DIM_EN
    // Scenario 6: dimming windows and deferred level change.
    dimIn = 2'd0;
    tick(1'b1);
    runTo(3); chk("dim0_c3", 8'(anode), 8'h0E);
    runTo(4); chk("dim0_c4", 8'(anode), 8'h0F);
    dimIn = 2'd3;
    runTo(12); chk("dim0_c12", 8'(anode), 8'h0F);
    runTo(FL + 3);
    dimIn = 2'd1;
    tick(1'b1);
    runTo(5); chk("dim1_c5", 8'(anode), 8'h0E);
    runTo(6); chk("dim1_c6", 8'(anode), 8'h0F);
`endif

    // Random segments, levels and occasional resets against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < 4; i++) segIn[i] = 8'($urandom);
      if ($urandom_range(0, 15) == 0) dimIn = 2'($urandom);
      tick($urandom_range(0, 199) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
